// File: rtl/redun_mont_seq.sv
// redun_mont_seq: iteration sequencer for the redundant-form Montgomery
// squaring core. Latches a start value and iteration count T, resets and
// launches the core, counts its outputs, and returns the value after T
// squarings (or the last completed value on abort).
// Optional periodic checkpoints: define REDUN_MONT_SEQ_CHECKPOINT_EN.
module redun_mont_seq #(
    parameter int unsigned NUM_WRDS     = 64,
    parameter int unsigned WRD_BITS     = 16,
    parameter int unsigned T_LEN        = 64,
    parameter int unsigned CORE_RST_CYC = 4,
    parameter int unsigned CHK_LOG2     = 10,
    localparam int unsigned RED_W       = NUM_WRDS * (WRD_BITS + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start_val,
    output logic             o_start_rdy,
    input  logic [RED_W-1:0] i_start_sq,
    input  logic [T_LEN-1:0] i_start_t,
    input  logic             i_abort,
    output logic             o_core_rst,
    output logic [RED_W-1:0] o_core_sq,
    output logic             o_core_val,
    input  logic [RED_W-1:0] i_core_mul,
    input  logic             i_core_val,
    output logic [RED_W-1:0] o_res,
    output logic [T_LEN-1:0] o_res_t,
    output logic             o_aborted,
    output logic             o_res_val,
    input  logic             i_res_rdy,
    output logic             o_busy,
    output logic [RED_W-1:0] o_chk,
    output logic [T_LEN-1:0] o_chk_t,
    output logic             o_chk_val
);

    localparam int unsigned CNT_W = (CORE_RST_CYC > 1) ? $clog2(CORE_RST_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CORE_RST_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        CORE_RST,
        LAUNCH,
        RUN,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [RED_W-1:0] sq_q;
    logic [T_LEN-1:0] t_q;
    logic [T_LEN-1:0] iter_q;
    logic [T_LEN-1:0] iter_inc;
    logic [RED_W-1:0] last_q;
    logic [RED_W-1:0] res_q;
    logic [T_LEN-1:0] res_t_q;
    logic             aborted_q;

    logic start_rdy_q, core_rst_q, core_val_q, res_val_q, busy_q;

    logic accept;
    logic fin;
    logic abort_run;
    logic core_step;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode and per-cycle event flags
    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        fin       = 1'b0;
        abort_run = 1'b0;
        core_step = 1'b0;
        iter_inc  = iter_q + 1'b1;
        case (state_q)
            IDLE: begin
                // The post-reset cycle sits in IDLE with ready still low.
                if (i_start_val && start_rdy_q) begin
                    accept  = 1'b1;
                    state_d = (i_start_t == '0) ? DONE : CORE_RST;
                end
            end
            CORE_RST: begin
                if (i_abort) begin
                    abort_run = 1'b1;
                    state_d   = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                if (i_abort) begin
                    abort_run = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Completion takes priority over a coincident abort.
                if (i_core_val && (iter_inc == t_q)) begin
                    fin     = 1'b1;
                    state_d = DONE;
                end else begin
                    core_step = i_core_val;
                    if (i_abort) begin
                        abort_run = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                if (i_res_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Run data: latched operands, iteration count, last value and result
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            sq_q      <= '0;
            t_q       <= '0;
            iter_q    <= '0;
            last_q    <= '0;
            res_q     <= '0;
            res_t_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            if (state_q == CORE_RST) cnt_q <= cnt_q + 1'b1;
            else                     cnt_q <= '0;

            if (accept) begin
                sq_q   <= i_start_sq;
                t_q    <= i_start_t;
                iter_q <= '0;
                last_q <= i_start_sq;
                if (i_start_t == '0) begin
                    res_q     <= i_start_sq;
                    res_t_q   <= '0;
                    aborted_q <= 1'b0;
                end
            end

            if (core_step) begin
                last_q <= i_core_mul;
                iter_q <= iter_inc;
            end

            if (fin) begin
                res_q     <= i_core_mul;
                res_t_q   <= t_q;
                aborted_q <= 1'b0;
            end else if (abort_run) begin
                aborted_q <= 1'b1;
                // A non-final output arriving with the abort is still counted.
                if (core_step) begin
                    res_q   <= i_core_mul;
                    res_t_q <= iter_inc;
                end else begin
                    res_q   <= last_q;
                    res_t_q <= iter_q;
                end
            end
        end
    end

    // Control outputs registered from the next state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            start_rdy_q <= 1'b0;
            core_rst_q  <= 1'b1;
            core_val_q  <= 1'b0;
            res_val_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            start_rdy_q <= (state_d == IDLE);
            core_rst_q  <= (state_d == IDLE) || (state_d == CORE_RST) || (state_d == DONE);
            core_val_q  <= (state_d == LAUNCH);
            res_val_q   <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign o_start_rdy = start_rdy_q;
    assign o_core_rst  = core_rst_q;
    assign o_core_sq   = sq_q;
    assign o_core_val  = core_val_q;
    assign o_res       = res_q;
    assign o_res_t     = res_t_q;
    assign o_aborted   = aborted_q;
    assign o_res_val   = res_val_q;
    assign o_busy      = busy_q;

`ifdef REDUN_MONT_SEQ_CHECKPOINT_EN
    localparam logic [T_LEN-1:0] CHK_MASK = (T_LEN'(1) << CHK_LOG2) - T_LEN'(1);

    logic [RED_W-1:0] chk_q;
    logic [T_LEN-1:0] chk_t_q;
    logic             chk_val_q;

    // One-cycle checkpoint strobe on every non-final multiple of the interval
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            chk_q     <= '0;
            chk_t_q   <= '0;
            chk_val_q <= 1'b0;
        end else begin
            chk_val_q <= 1'b0;
            if (core_step && ((iter_inc & CHK_MASK) == '0)) begin
                chk_q     <= i_core_mul;
                chk_t_q   <= iter_inc;
                chk_val_q <= 1'b1;
            end
        end
    end

    assign o_chk     = chk_q;
    assign o_chk_t   = chk_t_q;
    assign o_chk_val = chk_val_q;
`else
    assign o_chk     = '0;
    assign o_chk_t   = '0;
    assign o_chk_val = 1'b0;
`endif

endmodule
